// File: rtl/adc_align_pkg.sv
// Shared types and defaults for the ADC bring-up sequencer and its per-lane bitslip trainers.
package adc_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_CFG_WAIT,
    ST_SYNC,
    ST_TRAIN,
    ST_DONE,
    ST_FAIL
  } seq_state_e;

  typedef enum logic [2:0] {
    LN_CHECK,
    LN_SLIP,
    LN_SETTLE,
    LN_LOCKED,
    LN_LFAIL
  } lane_state_e;

  localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hA5;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lane_align_ctrl.sv
// Per-lane word aligner: checks the training word, pulses bitslip on mismatch, then settles.
// Lock/fail flags survive en_i dropping so they stay visible in DONE/FAIL until clr_i.
module lane_align_ctrl
  import adc_align_pkg::*;
#(
  parameter int               DESER         = 8,
  parameter logic [DESER-1:0] TRAIN_PATTERN = DESER'(TRAIN_PATTERN_DEF),
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 16,
  parameter int               MAX_SLIPS     = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DESER-1:0] word_i,
  output logic             bitslip_o,
  output logic             locked_o,
  output logic             fail_o
);

  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int SW = (MAX_SLIPS > 0) ? $clog2(MAX_SLIPS + 1) : 1;
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [MW-1:0] MATCH_FULL  = MW'(MATCH_COUNT);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  lane_state_e   state_q;
  logic [MW-1:0] match_q;
  logic [SW-1:0] slip_q;
  logic [TW-1:0] settle_q;
  logic          bitslip_q;
  logic          locked_q;
  logic          fail_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= LN_CHECK;
      match_q   <= '0;
      slip_q    <= '0;
      settle_q  <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else if (!en_i) begin
      state_q   <= LN_CHECK;
      match_q   <= '0;
      slip_q    <= '0;
      settle_q  <= '0;
      bitslip_q <= 1'b0;
      if (clr_i) begin
        locked_q <= 1'b0;
        fail_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        LN_CHECK: begin
          if (word_i == TRAIN_PATTERN) begin
            if (match_q == MATCH_LAST) begin
              state_q  <= LN_LOCKED;
              match_q  <= MATCH_FULL;
              locked_q <= 1'b1;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end else begin
            // Any mismatch restarts the run of consecutive matches.
            match_q <= '0;
            if (slip_q == SLIP_MAX) begin
              state_q <= LN_LFAIL;
              fail_q  <= 1'b1;
            end else begin
              state_q   <= LN_SLIP;
              bitslip_q <= 1'b1;
              slip_q    <= slip_q + 1'b1;
            end
          end
        end
        LN_SLIP: begin
          state_q   <= LN_SETTLE;
          bitslip_q <= 1'b0;
          settle_q  <= '0;
        end
        LN_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_q <= LN_CHECK;
          else settle_q <= settle_q + 1'b1;
        end
        LN_LOCKED, LN_LFAIL: ;
        default: state_q <= LN_CHECK;
      endcase
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = locked_q;
  assign fail_o    = fail_q;

endmodule

// File: rtl/adc_lane_align_seq.sv
// ADC bring-up sequencer: reset pulse, wait for SPI config, SYNC pulse, then per-lane bitslip training.
// Outputs are registered; bitslip is additionally masked outside TRAIN so DONE/FAIL never slip.
module adc_lane_align_seq
  import adc_align_pkg::*;
#(
  parameter int               NUM_LANES     = 10,
  parameter int               DESER         = 8,
  parameter logic [DESER-1:0] TRAIN_PATTERN = DESER'(TRAIN_PATTERN_DEF),
  parameter int               RST_CYCLES    = 16,
  parameter int               SYNC_CYCLES   = 4,
  parameter int               SETTLE_CYCLES = 4,
  parameter int               MATCH_COUNT   = 16,
  parameter int               MAX_SLIPS     = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       cfg_done_i,
  input  logic [NUM_LANES*DESER-1:0] lane_data_i,
  output logic                       adc_rst_n_o,
  output logic                       adc_sync_o,
  output logic [NUM_LANES-1:0]       bitslip_o,
  output logic [NUM_LANES-1:0]       lane_locked_o,
  output logic [NUM_LANES-1:0]       lane_fail_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fail_o
);

  localparam int TMR_MAX = max2(RST_CYCLES, SYNC_CYCLES + SETTLE_CYCLES);
  localparam int TW      = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] SYNC_LAST = TW'(SYNC_CYCLES - 1);
  localparam logic [TW-1:0] SEQ_LAST  = TW'(SYNC_CYCLES + SETTLE_CYCLES - 1);

  seq_state_e           state_q;
  logic [TW-1:0]        tmr_q;
  logic                 adc_rst_n_q;
  logic                 adc_sync_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 fail_q;
  logic [NUM_LANES-1:0] slip_raw;
  logic [NUM_LANES-1:0] lane_locked;
  logic [NUM_LANES-1:0] lane_fail;
  logic                 start_ok;
  logic                 train;

  assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_FAIL));
  assign train    = (state_q == ST_TRAIN);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      adc_rst_n_q <= 1'b1;
      adc_sync_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_i) begin
            state_q     <= ST_RST;
            tmr_q       <= '0;
            adc_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
          end
        end
        ST_RST: begin
          if (tmr_q == RST_LAST) begin
            state_q     <= ST_CFG_WAIT;
            tmr_q       <= '0;
            adc_rst_n_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_CFG_WAIT: begin
          if (cfg_done_i) begin
            state_q    <= ST_SYNC;
            tmr_q      <= '0;
            adc_sync_q <= 1'b1;
          end
        end
        ST_SYNC: begin
          // One timer covers the SYNC high phase followed by the post-SYNC settle.
          if (tmr_q == SEQ_LAST) begin
            state_q    <= ST_TRAIN;
            tmr_q      <= '0;
            adc_sync_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
            if (tmr_q == SYNC_LAST) adc_sync_q <= 1'b0;
          end
        end
        ST_TRAIN: begin
          if (|lane_fail) begin
            state_q <= ST_FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else if (&lane_locked) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_align_ctrl #(
      .DESER        (DESER),
      .TRAIN_PATTERN(TRAIN_PATTERN),
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .MATCH_COUNT  (MATCH_COUNT),
      .MAX_SLIPS    (MAX_SLIPS)
    ) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clr_i    (start_ok),
      .en_i     (train),
      .word_i   (lane_data_i[i*DESER +: DESER]),
      .bitslip_o(slip_raw[i]),
      .locked_o (lane_locked[i]),
      .fail_o   (lane_fail[i])
    );
  end

  assign adc_rst_n_o   = adc_rst_n_q;
  assign adc_sync_o    = adc_sync_q;
  assign bitslip_o     = slip_raw & {NUM_LANES{train}};
  assign lane_locked_o = lane_locked;
  assign lane_fail_o   = lane_fail;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign fail_o        = fail_q;

endmodule

// File: tb/tb_adc_lane_align_seq.sv
// Directed bench for adc_lane_align_seq with a bitslip-aware lane data model.
module tb_adc_lane_align_seq;

  localparam int         NL  = 10;
  localparam logic [7:0] PAT = 8'hA5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          cfg_done;
  logic [NL*8-1:0] lane_data;
  logic          adc_rst_n;
  logic          adc_sync;
  logic [NL-1:0] bitslip;
  logic [NL-1:0] lane_locked;
  logic [NL-1:0] lane_fail;
  logic          busy;
  logic          done;
  logic          fail;

  int rot [NL];
  logic [NL-1:0] bad;
  int n_checks, n_pass;
  int cyc, rst_low, sync_hi, stray;
  int pulses [NL];
  int last_pulse [NL];
  int min_gap [NL];

  always #5 clk = ~clk;

  adc_lane_align_seq dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .cfg_done_i   (cfg_done),
    .lane_data_i  (lane_data),
    .adc_rst_n_o  (adc_rst_n),
    .adc_sync_o   (adc_sync),
    .bitslip_o    (bitslip),
    .lane_locked_o(lane_locked),
    .lane_fail_o  (lane_fail),
    .busy_o       (busy),
    .done_o       (done),
    .fail_o       (fail)
  );

  function automatic logic [7:0] rotl(input logic [7:0] p, input int r);
    logic [15:0] t;
    t = {p, p} << r;
    return t[15:8];
  endfunction

  // Each lane shows the pattern rotated left by rot[i]; every bitslip rotates it back one bit.
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < NL; i++) lane_data[i*8 +: 8] = bad[i] ? 8'h00 : rotl(PAT, rot[i]);
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (adc_rst_n === 1'b0) rst_low++;
    if (adc_sync === 1'b1) sync_hi++;
    if ((done === 1'b1 || fail === 1'b1) && bitslip !== '0) stray++;
    for (int i = 0; i < NL; i++) begin
      if (bitslip[i] === 1'b1) begin
        pulses[i]++;
        if (last_pulse[i] >= 0 && (cyc - last_pulse[i]) < min_gap[i]) min_gap[i] = cyc - last_pulse[i];
        last_pulse[i] = cyc;
        if (rot[i] > 0) rot[i]--;
      end
    end
  endtask

  task automatic clear_stats();
    cyc = 0; rst_low = 0; sync_hi = 0; stray = 0;
    for (int i = 0; i < NL; i++) begin
      pulses[i] = 0; last_pulse[i] = -1; min_gap[i] = 1000;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Start is raised at negedge 0, so cyc counts negedges after the sampling edge.
  task automatic pulse_start();
    start = 1'b1;
    clear_stats();
    step();
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (done === 1'b1 || fail === 1'b1) begin
        t = cyc;
        break;
      end
      step();
    end
  endtask

  function automatic int total_pulses();
    int s;
    s = 0;
    for (int i = 0; i < NL; i++) s += pulses[i];
    return s;
  endfunction

  task automatic test_reset();
    do_reset();
    step();
    n_checks++; if ({adc_rst_n, adc_sync, busy, done, fail} !== 5'b10000) $display("FAIL reset_ctrl: got %b want 10000", {adc_rst_n, adc_sync, busy, done, fail}); else n_pass++;
    n_checks++; if ({bitslip, lane_locked, lane_fail} !== 30'h0) $display("FAIL reset_lanes: got %h want 0", {bitslip, lane_locked, lane_fail}); else n_pass++;
  endtask

  task automatic test_basic();
    int t;
    pulse_start();
    n_checks++; if ({adc_rst_n, busy} !== 2'b01) $display("FAIL basic_rst_edge: got %b want 01", {adc_rst_n, busy}); else n_pass++;
    while (cyc < 17) step();
    n_checks++; if ({adc_rst_n, adc_sync} !== 2'b10) $display("FAIL basic_cfg_wait: got %b want 10", {adc_rst_n, adc_sync}); else n_pass++;
    step();
    n_checks++; if (adc_sync !== 1'b1) $display("FAIL basic_sync_rise: got %b want 1", adc_sync); else n_pass++;
    while (cyc < 41) step();
    n_checks++; if (lane_locked !== 10'h000) $display("FAIL basic_prelock: got %h want 000", lane_locked); else n_pass++;
    step();
    n_checks++; if ({lane_locked, done} !== {10'h3FF, 1'b0}) $display("FAIL basic_lock: got %h want 7fe", {lane_locked, done}); else n_pass++;
    wait_end(100, t);
    n_checks++; if (t !== 43) $display("FAIL basic_done_time: got %0d want 43", t); else n_pass++;
    n_checks++; if (rst_low !== 16) $display("FAIL basic_rst_len: got %0d want 16", rst_low); else n_pass++;
    n_checks++; if (sync_hi !== 4) $display("FAIL basic_sync_len: got %0d want 4", sync_hi); else n_pass++;
    n_checks++; if (total_pulses() !== 0) $display("FAIL basic_slips: got %0d want 0", total_pulses()); else n_pass++;
    n_checks++; if ({done, fail, busy} !== 3'b100) $display("FAIL basic_status: got %b want 100", {done, fail, busy}); else n_pass++;
  endtask

  task automatic test_slip_lane3();
    int t;
    rot[3] = 3;
    pulse_start();
    n_checks++; if ({lane_locked, done} !== 11'h0) $display("FAIL slip_restart_clear: got %h want 0", {lane_locked, done}); else n_pass++;
    wait_end(200, t);
    n_checks++; if (t !== 61) $display("FAIL slip_done_time: got %0d want 61", t); else n_pass++;
    n_checks++; if (pulses[3] !== 3) $display("FAIL slip_count_l3: got %0d want 3", pulses[3]); else n_pass++;
    n_checks++; if (total_pulses() !== 3) $display("FAIL slip_other_lanes: got %0d want 3 total", total_pulses()); else n_pass++;
    n_checks++; if (min_gap[3] !== 6) $display("FAIL slip_gap: got %0d want 6", min_gap[3]); else n_pass++;
    n_checks++; if ({lane_locked, done, fail} !== {10'h3FF, 2'b10}) $display("FAIL slip_status: got %h want ffe", {lane_locked, done, fail}); else n_pass++;
  endtask

  task automatic test_lane_fail();
    int t;
    bad[0] = 1'b1;
    pulse_start();
    wait_end(400, t);
    n_checks++; if (t !== 124) $display("FAIL lfail_time: got %0d want 124", t); else n_pass++;
    n_checks++; if (pulses[0] !== 16 || total_pulses() !== 16) $display("FAIL lfail_slips: got %0d/%0d want 16/16", pulses[0], total_pulses()); else n_pass++;
    n_checks++; if ({fail, done} !== 2'b10) $display("FAIL lfail_status: got %b want 10", {fail, done}); else n_pass++;
    n_checks++; if ({lane_fail, lane_locked} !== {10'h001, 10'h3FE}) $display("FAIL lfail_lanes: got %h want 007fe", {lane_fail, lane_locked}); else n_pass++;
    repeat (5) step();
    n_checks++; if (stray !== 0 || bitslip !== '0) $display("FAIL lfail_quiet: got %0d/%h want 0/0", stray, bitslip); else n_pass++;
    bad[0] = 1'b0;
  endtask

  task automatic test_cfg_wait();
    int t;
    do_reset();
    cfg_done = 1'b0;
    pulse_start();
    while (cyc < 110) step();
    n_checks++; if (sync_hi !== 0) $display("FAIL cfgw_no_sync: got %0d want 0", sync_hi); else n_pass++;
    n_checks++; if ({adc_rst_n, busy, adc_sync} !== 3'b110) $display("FAIL cfgw_hold: got %b want 110", {adc_rst_n, busy, adc_sync}); else n_pass++;
    cfg_done = 1'b1;
    step();
    n_checks++; if (adc_sync !== 1'b1) $display("FAIL cfgw_sync_rise: got %b want 1", adc_sync); else n_pass++;
    wait_end(200, t);
    n_checks++; if (t !== 136) $display("FAIL cfgw_done_time: got %0d want 136", t); else n_pass++;
  endtask

  task automatic test_rematch();
    int t;
    pulse_start();
    while (cyc < 36) step();
    bad[2] = 1'b1;
    step();
    bad[2] = 1'b0;
    n_checks++; if (bitslip !== 10'h004) $display("FAIL remat_slip: got %h want 004", bitslip); else n_pass++;
    while (cyc < 57) step();
    n_checks++; if (lane_locked !== 10'h3FB) $display("FAIL remat_prelock: got %h want 3fb", lane_locked); else n_pass++;
    step();
    n_checks++; if (lane_locked !== 10'h3FF) $display("FAIL remat_lock: got %h want 3ff", lane_locked); else n_pass++;
    wait_end(100, t);
    n_checks++; if (t !== 59) $display("FAIL remat_done_time: got %0d want 59", t); else n_pass++;
    n_checks++; if (pulses[2] !== 1 || total_pulses() !== 1) $display("FAIL remat_slips: got %0d/%0d want 1/1", pulses[2], total_pulses()); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int t;
    rot[3] = 3;
    pulse_start();
    while (cyc < 50) step();
    n_checks++; if ({lane_locked, busy} !== {10'h3F7, 1'b1}) $display("FAIL abort_train_pre: got %h want 7ef", {lane_locked, busy}); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({adc_rst_n, adc_sync, busy, done, fail} !== 5'b10000) $display("FAIL abort_train_ctrl: got %b want 10000", {adc_rst_n, adc_sync, busy, done, fail}); else n_pass++;
    n_checks++; if ({bitslip, lane_locked, lane_fail} !== 30'h0) $display("FAIL abort_train_lanes: got %h want 0", {bitslip, lane_locked, lane_fail}); else n_pass++;
    rot[3] = 0;
    clear_stats();
    repeat (30) step();
    n_checks++; if (rst_low + sync_hi + total_pulses() !== 0 || busy !== 1'b0) $display("FAIL abort_quiet: got %0d/%b want 0/0", rst_low + sync_hi + total_pulses(), busy); else n_pass++;

    pulse_start();
    while (cyc < 5) step();
    n_checks++; if (adc_rst_n !== 1'b0) $display("FAIL abort_rst_pre: got %b want 0", adc_rst_n); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if ({adc_rst_n, busy} !== 2'b10) $display("FAIL abort_rst_ctrl: got %b want 10", {adc_rst_n, busy}); else n_pass++;

    pulse_start();
    while (cyc < 10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 17) step();
    n_checks++; if (rst_low !== 16 || adc_rst_n !== 1'b1) $display("FAIL busy_start_ignored: got %0d/%b want 16/1", rst_low, adc_rst_n); else n_pass++;
    wait_end(100, t);
    n_checks++; if (t !== 43 || done !== 1'b1) $display("FAIL restart_done: got %0d/%b want 43/1", t, done); else n_pass++;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    cfg_done = 1'b1;
    bad      = '0;
    for (int i = 0; i < NL; i++) rot[i] = 0;
    n_checks = 0;
    n_pass   = 0;
    clear_stats();
    test_reset();
    test_basic();
    test_slip_lane3();
    test_lane_fail();
    test_cfg_wait();
    test_rematch();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_lane_align_seq.md
Name: adc_lane_align_seq

Overview:
Parametrised bring-up sequencer for multi-lane LVDS ADCs. Pulses the ADC reset, waits for the SPI configuration engine, then issues the SYNC pulse. It then trains every deserialized lane against a known pattern by stepping ISERDES bitslip until each lane locks. Sits between the SPI config wrapper and the ISERDES data path, and replaces fixed counter-based reset/sync generation.

Parameters:
NUM_LANES, 10, number of deserialized data lanes
DESER, 8, bits per lane per clk (ISERDES ratio)
TRAIN_PATTERN, 8'hA5, expected per-lane word during training (DESER bits)
RST_CYCLES, 16, adc_rst_n low time in clk cycles (>=1)
SYNC_CYCLES, 4, adc_sync high time in clk cycles (>=1)
SETTLE_CYCLES, 4, wait after each bitslip before re-checking data (>=1)
MATCH_COUNT, 16, consecutive matching words required for lane lock (>=1)
MAX_SLIPS, 16, bitslips allowed per lane before lane failure

Ports:
clk  in  1  single system clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  single-cycle request to run the full sequence
cfg_done  in  1  SPI configuration complete, level
lane_data  in  NUM_LANES*DESER  ISERDES words, lane i = [i*DESER +: DESER]
adc_rst_n  out  1  ADC reset, active low
adc_sync  out  1  ADC SYNC, active high (drives OBUFDS externally)
bitslip  out  NUM_LANES  one-cycle bitslip pulses per lane
lane_locked  out  NUM_LANES  per-lane lock status
lane_fail  out  NUM_LANES  per-lane failure status
busy  out  1  high in every state except IDLE, DONE and FAIL
done  out  1  high in DONE
fail  out  1  high in FAIL

Behaviour:
- Reset: state=IDLE. adc_rst_n=1, adc_sync=0, bitslip=0, lane_locked=0, lane_fail=0, busy=0, done=0, fail=0. All counters are cleared. Reset mid-sequence aborts immediately, with no further pulses.
- Top FSM: IDLE -> RST -> CFG_WAIT -> SYNC -> TRAIN -> DONE | FAIL.
- IDLE/DONE/FAIL: start=1 clears lane_locked/lane_fail and enters RST on the next cycle. start in any other state is ignored.
- RST: adc_rst_n=0 for exactly RST_CYCLES cycles, then CFG_WAIT.
- CFG_WAIT: adc_rst_n=1. Stays while cfg_done=0. cfg_done sampled high -> SYNC. No timeout (the SPI engine owns its own timeout).
- SYNC: adc_sync=1 for exactly SYNC_CYCLES cycles. Then waits SETTLE_CYCLES with adc_sync=0, then TRAIN.
- TRAIN: all lanes run independently in parallel.
  - All lanes locked -> DONE the next cycle.
  - Any lane_fail -> FAIL the next cycle.
  - Fail takes priority if both occur in the same cycle.
- DONE/FAIL: bitslip forced 0. lane_locked/lane_fail hold until the next start or reset. No lock monitoring on live data.
- Per-lane FSM (active only in TRAIN): CHECK -> SLIP -> SETTLE -> CHECK; LOCKED and LFAIL are terminal.
  - CHECK: word==TRAIN_PATTERN increments the match counter. A match count reaching MATCH_COUNT -> LOCKED (lane_locked=1).
  - CHECK mismatch: clear the match counter. If slip_cnt==MAX_SLIPS -> LFAIL (lane_fail=1); otherwise -> SLIP.
  - SLIP: bitslip[i]=1 for exactly one cycle, slip_cnt+1, then SETTLE.
  - SETTLE: SETTLE_CYCLES cycles ignoring data, then CHECK.
  - Lock on the first word with zero slips is legal.
  - Leaving TRAIN (abort/start) returns lanes to CHECK with counters cleared.
- Counter widths: $clog2(max+1) each. There is no wrap; counters saturate at their terminal compare.
- Latency, cfg_done already high: start -> adc_rst_n low at +1. SYNC rises at +1+RST_CYCLES+1. Training starts SYNC_CYCLES+SETTLE_CYCLES after SYNC rises.

Decomposition:
- Shared package adc_align_pkg holds:
  - top state enum (IDLE, RST, CFG_WAIT, SYNC, TRAIN, DONE, FAIL)
  - lane state enum (CHECK, SLIP, SETTLE, LOCKED, LFAIL)
  - the default TRAIN_PATTERN constant
- Sub-module lane_align_ctrl: per-lane FSM, match and slip counters. Generated NUM_LANES times.
- The top holds the sequence FSM and the timers.

Test Plan:
- Defaults, cfg_done tied 1, all lanes present 8'hA5. Pulse start -> adc_rst_n low exactly 16 cycles, adc_sync high exactly 4 cycles, zero bitslips, all lanes locked 16 cycles into TRAIN, done=1.
- Lane 3 presents pattern rotated by 3 bits; the bench model rotates back one bit per bitslip -> exactly 3 bitslip[3] pulses, each followed by 4 quiet cycles. Lane 3 locks, other lanes get no slips, done=1.
- Lane 0 data never matches (8'h00) -> exactly 16 bitslip[0] pulses, lane_fail[0]=1, fail=1, done=0, bitslip=0 in FAIL.
- cfg_done held low 100 cycles after reset release -> FSM stays in CFG_WAIT, adc_sync=0. cfg_done rise -> SYNC pulse on the next cycle.
- Lane matches 10 words then one mismatch -> match counter restarts, one bitslip issued, lock requires 16 fresh consecutive matches.
- reset asserted mid-TRAIN and mid-RST -> all outputs at reset values on the next cycle. start accepted again afterwards. start during busy has no effect.
